// File: rtl/arr_mul_8_pipe.sv
// arr_mul_8_pipe: unsigned 8x8 array multiplier with a registered input stage
// and a registered output stage, giving a 2-cycle latency and one product per
// cycle. The partial products are reduced by explicit rows of ripple adders.
// A valid flag moves through the pipeline alongside the data.
//
// Optional build macro: ARR_MUL_MID_PIPE_EN
//   When defined, a register stage is inserted after array row 3. Latency
//   becomes 3 cycles, throughput stays at one product per cycle, and the
//   product values are unchanged.
//
// Handshake: in_valid qualifies A/B in the cycle they are sampled. out_valid
// qualifies out, which is registered on every cycle. There is no ready and no
// backpressure.
module arr_mul_8_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] out,
  output logic        out_valid
);

  // One adder row. x is the partial product for this row. y is the previous
  // row's {carry, sum[7:1]}. Bit 0 is a half adder and bits 1..7 are full
  // adders. The result is {carry_out, sum[7:0]}.
  function automatic logic [8:0] row_add(input logic [7:0] x,
                                         input logic [7:0] y);
    logic [7:0] s;
    logic [8:0] c;
    s    = 8'h00;
    c    = 9'h000;
    s[0] = x[0] ^ y[0];
    c[1] = x[0] & y[0];
    for (int k = 1; k < 8; k++) begin
      s[k]   = x[k] ^ y[k] ^ c[k];
      c[k+1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
    end
    return {c[8], s};
  endfunction

  // Input stage registers
  logic [7:0]  r_a_q;
  logic [7:0]  r_b_q;
  logic        r_v_q;

  // Front array rows 0..3, computed from the input stage
  logic [8:0]  w_row0;
  logic [8:0]  w_row1;
  logic [8:0]  w_row2;
  logic [8:0]  w_row3;
  logic [3:0]  w_lo_f;

  // Values seen by rows 4..7. These are registered or passed straight through.
  logic [8:0]  w_row3_b;
  logic [3:0]  w_lo_b;
  logic [7:0]  w_a_b;
  logic [3:0]  w_bh_b;
  logic        w_v_b;

  // Back array rows 4..7 and the final product
  logic [8:0]  w_row4;
  logic [8:0]  w_row5;
  logic [8:0]  w_row6;
  logic [8:0]  w_row7;
  logic [15:0] w_product;

  // Output stage registers
  logic [15:0] r_out;
  logic        r_out_valid;

  // Input stage captures on every edge. Downstream logic ignores A/B when in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= 8'h00;
      r_b_q <= 8'h00;
      r_v_q <= 1'b0;
    end else begin
      r_a_q <= A;
      r_b_q <= B;
      r_v_q <= in_valid;
    end
  end

  // Rows 0..3. Row 0 is the bare partial product and has no carry.
  always_comb begin
    w_row0 = {1'b0, r_a_q & {8{r_b_q[0]}}};
    w_row1 = row_add(r_a_q & {8{r_b_q[1]}}, w_row0[8:1]);
    w_row2 = row_add(r_a_q & {8{r_b_q[2]}}, w_row1[8:1]);
    w_row3 = row_add(r_a_q & {8{r_b_q[3]}}, w_row2[8:1]);
    w_lo_f = {w_row3[0], w_row2[0], w_row1[0], w_row0[0]};
  end

`ifdef ARR_MUL_MID_PIPE_EN
  logic [8:0]  r_m_row3;
  logic [3:0]  r_m_lo;
  logic [7:0]  r_m_a;
  logic [3:0]  r_m_bh;
  logic        r_m_v;

  // Mid stage holds the row-3 running sum, the product bits already
  // settled, the operand bits that rows 4..7 still need, and the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_row3 <= 9'h000;
      r_m_lo   <= 4'h0;
      r_m_a    <= 8'h00;
      r_m_bh   <= 4'h0;
      r_m_v    <= 1'b0;
    end else begin
      r_m_row3 <= w_row3;
      r_m_lo   <= w_lo_f;
      r_m_a    <= r_a_q;
      r_m_bh   <= r_b_q[7:4];
      r_m_v    <= r_v_q;
    end
  end

  assign w_row3_b = r_m_row3;
  assign w_lo_b   = r_m_lo;
  assign w_a_b    = r_m_a;
  assign w_bh_b   = r_m_bh;
  assign w_v_b    = r_m_v;
`else
  assign w_row3_b = w_row3;
  assign w_lo_b   = w_lo_f;
  assign w_a_b    = r_a_q;
  assign w_bh_b   = r_b_q[7:4];
  assign w_v_b    = r_v_q;
`endif

  // Rows 4..7. The last row supplies product[15:7].
  always_comb begin
    w_row4    = row_add(w_a_b & {8{w_bh_b[0]}}, w_row3_b[8:1]);
    w_row5    = row_add(w_a_b & {8{w_bh_b[1]}}, w_row4[8:1]);
    w_row6    = row_add(w_a_b & {8{w_bh_b[2]}}, w_row5[8:1]);
    w_row7    = row_add(w_a_b & {8{w_bh_b[3]}}, w_row6[8:1]);
    w_product = {w_row7, w_row6[0], w_row5[0], w_row4[0], w_lo_b};
  end

  // Output stage registers the product on every cycle and carries the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 16'h0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_product;
      r_out_valid <= w_v_b;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arr_mul_8_pipe.sv
// Testbench for arr_mul_8_pipe. The latency follows ARR_MUL_MID_PIPE_EN.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// 1 time unit after a rising edge.
module tb_arr_mul_8_pipe;

`ifdef ARR_MUL_MID_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] out;
  logic        out_valid;

  int tests_run;
  int tests_failed;

  // Directed vectors with hand-computed products
  logic [7:0]  vec_a [0:5];
  logic [7:0]  vec_b [0:5];
  logic [15:0] vec_p [0:5];

  arr_mul_8_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out       (out),
    .out_valid (out_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    A        = a;
    B        = b;
  endtask

  task automatic test_reset();
    // Check the state just after reset has been asserted.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    #3;
    tests_run++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_initial: out=%h valid=%b, required out=0000 valid=0", out, out_valid);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    // Fill the pipeline with valid work, then assert reset between edges.
    for (int i = 0; i < LAT + 1; i++) begin
      drive(1'b1, 8'hFF, 8'hFF);
      step();
    end
    tests_run++;
    if (out !== 16'hFE01 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prefill: out=%h valid=%b, required out=fe01 valid=1", out, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_clear: out=%h valid=%b, required out=0000 valid=0", out, out_valid);
    end
    step();
    step();
    // Release reset with in_valid low. No stale result may appear afterwards.
    #2;
    rst_n = 1'b1;
    drive(1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_stale cyc=%0d: valid=%b, required 0", i, out_valid);
      end
    end
    // The first valid input after reset appears exactly LAT edges later.
    drive(1'b1, 8'h03, 8'h07);
    for (int i = 1; i <= LAT; i++) begin
      step();
      drive(1'b0, 8'h00, 8'h00);
      tests_run++;
      if (i < LAT && out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_first_early cyc=%0d: valid=%b, required 0", i, out_valid);
      end else if (i == LAT && (out_valid !== 1'b1 || out !== 16'h0015)) begin
        tests_failed++;
        $display("FAIL reset_first_valid: out=%h valid=%b, required out=0015 valid=1", out, out_valid);
      end
    end
    step();
  endtask

  task automatic test_directed();
    for (int v = 0; v < 6; v++) begin
      drive(1'b1, vec_a[v], vec_b[v]);
      step();
      drive(1'b0, 8'h00, 8'h00);
      for (int i = 1; i < LAT; i++) step();
      tests_run++;
      if (out !== vec_p[v] || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed %0d*%0d: out=%h valid=%b, required out=%h valid=1",
                 vec_a[v], vec_b[v], out, out_valid, vec_p[v]);
      end
      for (int i = 0; i < LAT; i++) step();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6 + LAT; c++) begin
      if (c < 6) drive(1'b1, vec_a[c], vec_b[c]);
      else       drive(1'b0, 8'h00, 8'h00);
      step();
      if (c - LAT + 1 >= 0) begin
        tests_run++;
        if (c - LAT + 1 < 6) begin
          if (out !== vec_p[c-LAT+1] || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back idx=%0d: out=%h valid=%b, required out=%h valid=1",
                     c - LAT + 1, out, out_valid, vec_p[c-LAT+1]);
          end
        end else if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL back_to_back_tail: valid=%b, required 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic exp_v [0:15];
    for (int c = 0; c < 16; c++) exp_v[c] = (c % 2 == 0);
    for (int c = 0; c < 16 + LAT; c++) begin
      if (c < 16) drive(exp_v[c], 8'h0F, 8'h0F);
      else        drive(1'b0, 8'h0F, 8'h0F);
      step();
      if (c - LAT + 1 >= 0 && c - LAT + 1 < 16) begin
        tests_run++;
        if (out_valid !== exp_v[c-LAT+1] ||
            (exp_v[c-LAT+1] && out !== 16'h00E1)) begin
          tests_failed++;
          $display("FAIL valid_gaps idx=%0d: out=%h valid=%b, required valid=%b out=00e1 when valid",
                   c - LAT + 1, out, out_valid, exp_v[c-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_identity();
    logic [7:0]  ia [0:3];
    logic [7:0]  ib [0:3];
    logic [15:0] ip [0:3];
    ia[0] = 8'h80; ib[0] = 8'h02; ip[0] = 16'h0100;
    ia[1] = 8'h02; ib[1] = 8'h80; ip[1] = 16'h0100;
    ia[2] = 8'h01; ib[2] = 8'hA5; ip[2] = 16'h00A5;
    ia[3] = 8'h37; ib[3] = 8'h00; ip[3] = 16'h0000;
    for (int c = 0; c < 4 + LAT; c++) begin
      if (c < 4) drive(1'b1, ia[c], ib[c]);
      else       drive(1'b0, 8'h00, 8'h00);
      step();
      if (c - LAT + 1 >= 0 && c - LAT + 1 < 4) begin
        tests_run++;
        if (out !== ip[c-LAT+1] || out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL identity %h*%h: out=%h valid=%b, required out=%h valid=1",
                   ia[c-LAT+1], ib[c-LAT+1], out, out_valid, ip[c-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] idx;
    logic [15:0] expv;
    int          errs;
    errs = 0;
    for (int c = 0; c < 65536 + LAT - 1; c++) begin
      if (c < 65536) begin
        idx = c[15:0];
        drive(1'b1, idx[15:8], idx[7:0]);
      end else begin
        drive(1'b0, 8'h00, 8'h00);
      end
      step();
      if (c - LAT + 1 >= 0) begin
        idx  = 16'(c - LAT + 1);
        expv = 16'(32'(idx[15:8]) * 32'(idx[7:0]));
        tests_run++;
        if (out !== expv || out_valid !== 1'b1) begin
          tests_failed++;
          errs++;
          if (errs <= 50)
            $display("FAIL exhaustive %0d*%0d: out=%h valid=%b, required out=%h valid=1",
                     idx[15:8], idx[7:0], out, out_valid, expv);
        end
      end
    end
    step();
    if (errs > 50)
      $display("FAIL exhaustive: %0d mismatching pairs in total, only the first 50 listed", errs);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vec_a[0] = 8'd2;   vec_b[0] = 8'd3;   vec_p[0] = 16'h0006;
    vec_a[1] = 8'd5;   vec_b[1] = 8'd6;   vec_p[1] = 16'h001E;
    vec_a[2] = 8'd255; vec_b[2] = 8'd1;   vec_p[2] = 16'h00FF;
    vec_a[3] = 8'd170; vec_b[3] = 8'd85;  vec_p[3] = 16'h3872;
    vec_a[4] = 8'd0;   vec_b[4] = 8'd255; vec_p[4] = 16'h0000;
    vec_a[5] = 8'd255; vec_b[5] = 8'd255; vec_p[5] = 16'hFE01;

    test_reset();
    test_directed();
    test_back_to_back();
    test_valid_gaps();
    test_identity();
    test_exhaustive();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arr_mul_8_pipe.md
Name: arr_mul_8_pipe

Overview:
- Unsigned 8x8 array multiplier producing a full 16-bit product.
- Partial products are reduced through an explicit adder array (rows of full/half adders), not an inferred `*` operator.
- Registered at input and output for use as a fixed-latency datapath block.
- Valid flag travels alongside the data.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B qualify a new operation this cycle
- A  input  8  multiplicand, unsigned
- B  input  8  multiplier, unsigned
- out  output  16  product A*B, unsigned
- out_valid  output  1  out holds a valid product this cycle

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All pipeline registers clear immediately, regardless of clk.
  - out=16'h0000, out_valid=0.
  - Operations in flight are discarded and never emerge.
- Stage 1 (input register): on each rising clk, capture A, B and in_valid into internal registers a_q, b_q, v_q.
  - Capture is unconditional. A/B are captured even when in_valid=0 but are ignored downstream.
- Array, combinational from a_q/b_q:
  - Partial product pp[i][j] = a_q[j] & b_q[i], for i,j in 0..7.
  - Row 0 is pp[0] directly.
  - Rows 1..7 each add pp[i] to the shifted running sum with an 8-bit ripple row of full adders; the LSB of each row is a half adder.
  - The carry-out of each row feeds the MSB of the next row.
  - product[i] is taken from the LSB of row i. The final row supplies product[15:7].
- Stage 2 (output register): on rising clk, out <= array result, out_valid <= v_q.
  - out updates every cycle, irrespective of valid.
  - Consumers must qualify out with out_valid.
- Latency: exactly 2 clk rising edges from the A/B/in_valid sample to out/out_valid.
- Throughput: one operation per cycle. No stall or backpressure.
- Arithmetic:
  - Result is exact. The maximum 255*255 = 65025 fits in 16 bits, so there is no overflow and no truncation.
  - Operands are unsigned only; no signed mode.
- Boundaries:
  - Either operand 0 gives 0.
  - Either operand 1 gives the other operand, zero-extended.
  - Back-to-back valid inputs produce back-to-back valid outputs in the same order.
  - in_valid=0 cycles produce out_valid=0 cycles at the same pipeline position.
  - Reset deasserting mid-stream: the first out_valid=1 occurs 2 edges after the first in_valid=1 sampled post-reset.

Optional Feature:
- Macro: ARR_MUL_MID_PIPE_EN.
- When defined:
  - An extra register stage sits after array row 3. It holds the partial running sum, the upper operand bits still needed (b_q[7:4], a_q) and v_q.
  - Rows 4..7 are computed from the registered values.
  - Latency becomes 3 cycles; throughput stays 1/cycle.
  - The extra stage is cleared by rst_n like all other registers.
- When undefined: pure 2-cycle latency as described above.
- Product values are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-operation with in_valid=1 -> out=0x0000 and out_valid=0 immediately; no stale result appears after release.
- Directed vectors, one per cycle with in_valid=1, each checked at latency:
  - 2*3 -> 0x0006
  - 5*6 -> 0x001E
  - 255*1 -> 0x00FF
  - 170*85 -> 0x3872
  - 0*255 -> 0x0000
  - 255*255 -> 0xFE01
- Back-to-back streaming: apply the 6 vectors on consecutive cycles -> 6 consecutive out_valid=1 results, in order, at fixed latency.
- Valid gaps: alternate in_valid 1/0 with A=B=0x0F -> out_valid toggles 1/0, and each valid out=0x00E1.
- Exhaustive: all 65536 A/B pairs -> out == A*B against a behavioural model. Run in both builds: latency 2 without ARR_MUL_MID_PIPE_EN, latency 3 with it.
- Identity/commutativity: A=0x80,B=0x02 and A=0x02,B=0x80 -> both 0x0100.
